// File: rtl/pc_npc_sequencer.sv
// pc_npc_sequencer: SPARC-style PC/nPC sequencer with delayed branches, annul, stall hold and trap-entry FSM.
module pc_npc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int              DRAIN_CYCLES = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            ctrl_valid,
   input  logic            ctrl_taken,
   input  logic            ctrl_uncond,
   input  logic            ctrl_annul,
   input  logic [XLEN-1:0] ctrl_target,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_vector,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] npc,
   output logic            fetch_valid,
   output logic            in_delay_slot,
   output logic [XLEN-1:0] epc,
   output logic [XLEN-1:0] enpc,
   output logic            trap_busy
);
   typedef enum logic [1:0] {RUN, DRAIN, VECTOR} state_t;
   state_t state, state_d;
   logic [3:0] cnt, cnt_d;
   logic [XLEN-1:0] pc_d, npc_d, epc_d, enpc_d, tgt, vec;
   logic fv_d, ds_d;
   assign tgt = {ctrl_target[XLEN-1:2], 2'b00};
   assign vec = {trap_vector[XLEN-1:2], 2'b00};
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      pc_d    = pc;
      npc_d   = npc;
      fv_d    = fetch_valid;
      ds_d    = in_delay_slot;
      epc_d   = epc;
      enpc_d  = enpc;
      case (state)
         RUN:
            if (trap_req) begin
               epc_d   = pc;
               enpc_d  = npc;
               cnt_d   = 4'(DRAIN_CYCLES - 1);
               fv_d    = 1'b0;
               state_d = DRAIN;
            end else if (!stall) begin
               fv_d = 1'b1;
               ds_d = 1'b0;
               if (ctrl_valid && ctrl_taken && ctrl_uncond && ctrl_annul) begin
                  pc_d  = tgt;
                  npc_d = tgt + XLEN'(4);
               end else if (ctrl_valid && ctrl_taken) begin
                  pc_d  = npc;
                  npc_d = tgt;
                  ds_d  = 1'b1;
               end else if (ctrl_valid && ctrl_annul) begin
                  // untaken annulling branch skips its delay slot
                  pc_d  = npc + XLEN'(4);
                  npc_d = npc + XLEN'(8);
               end else begin
                  pc_d  = npc;
                  npc_d = npc + XLEN'(4);
               end
            end
         DRAIN: begin
            fv_d = 1'b0;
            if (cnt == 4'd0) state_d = VECTOR;
            else cnt_d = cnt - 4'd1;
         end
         VECTOR: begin
            pc_d    = vec;
            npc_d   = vec + XLEN'(4);
            fv_d    = 1'b1;
            ds_d    = 1'b0;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= RUN;
         cnt           <= '0;
         pc            <= RESET_PC;
         npc           <= RESET_PC + XLEN'(4);
         fetch_valid   <= 1'b1;
         in_delay_slot <= 1'b0;
         epc           <= '0;
         enpc          <= '0;
         trap_busy     <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         pc            <= pc_d;
         npc           <= npc_d;
         fetch_valid   <= fv_d;
         in_delay_slot <= ds_d;
         epc           <= epc_d;
         enpc          <= enpc_d;
         trap_busy     <= (state_d != RUN);
      end
   end
endmodule

// File: tb/tb_pc_npc_sequencer.sv
// tb_pc_npc_sequencer: directed checks of branch, annul, stall, trap and wrap behaviour.
module tb_pc_npc_sequencer;
   logic clk = 1'b0, reset = 1'b1, stall = 1'b0;
   logic ctrl_valid = 1'b0, ctrl_taken = 1'b0, ctrl_uncond = 1'b0, ctrl_annul = 1'b0;
   logic [31:0] ctrl_target = '0, trap_vector = '0;
   logic trap_req = 1'b0;
   logic [31:0] pc, npc, epc, enpc;
   logic fetch_valid, in_delay_slot, trap_busy;
   int passed = 0, total = 0;

   pc_npc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .reset(reset), .stall(stall), .ctrl_valid(ctrl_valid), .ctrl_taken(ctrl_taken),
      .ctrl_uncond(ctrl_uncond), .ctrl_annul(ctrl_annul), .ctrl_target(ctrl_target),
      .trap_req(trap_req), .trap_vector(trap_vector), .pc(pc), .npc(npc),
      .fetch_valid(fetch_valid), .in_delay_slot(in_delay_slot), .epc(epc), .enpc(enpc),
      .trap_busy(trap_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cti(input logic v, input logic t, input logic u, input logic a, input logic [31:0] tg);
      ctrl_valid = v; ctrl_taken = t; ctrl_uncond = u; ctrl_annul = a; ctrl_target = tg;
   endtask

   task automatic pair(input string tag, input logic [31:0] p, input logic [31:0] n);
      chk({tag, "_pc"}, pc, p);
      chk({tag, "_npc"}, npc, n);
   endtask

   initial begin
      repeat (2) tick();
      pair("rst", 0, 4);
      chk("rst_fv", 32'(fetch_valid), 1);
      chk("rst_ds", 32'(in_delay_slot), 0);
      chk("rst_epc", epc, 0);
      chk("rst_enpc", enpc, 0);
      chk("rst_busy", 32'(trap_busy), 0);
      reset = 1'b0;
      tick(); pair("seq1", 4, 8);
      tick(); pair("seq2", 8, 12);
      cti(1, 1, 0, 0, 32'h40);
      tick(); cti(0, 0, 0, 0, 0);
      pair("br", 12, 32'h40);
      chk("br_ds", 32'(in_delay_slot), 1);
      chk("br_fv", 32'(fetch_valid), 1);
      tick(); pair("br_tgt", 32'h40, 32'h44);
      chk("br_tgt_ds", 32'(in_delay_slot), 0);
      tick(); pair("seq3", 32'h44, 32'h48);
      #2 reset = 1'b1;
      #1 pair("async_rst", 0, 4);
      reset = 1'b0;
      tick(); tick(); pair("seq4", 8, 12);
      cti(1, 0, 0, 1, 32'h40);
      tick(); pair("nt_annul", 16, 20);
      chk("nt_annul_ds", 32'(in_delay_slot), 0);
      cti(1, 0, 0, 0, 32'h40);
      tick(); pair("nt_plain", 20, 24);
      cti(1, 1, 1, 1, 32'h103);
      tick(); pair("ba_a", 32'h100, 32'h104);
      chk("ba_a_ds", 32'(in_delay_slot), 0);
      cti(1, 1, 0, 0, 32'h200);
      stall = 1'b1;
      tick(); pair("stall1", 32'h100, 32'h104);
      tick(); pair("stall2", 32'h100, 32'h104);
      stall = 1'b0;
      tick(); pair("unstall", 32'h104, 32'h200);
      chk("unstall_ds", 32'(in_delay_slot), 1);
      cti(1, 1, 1, 1, 32'h20);
      tick(); pair("to20", 32'h20, 32'h24);
      cti(1, 1, 0, 0, 32'h500);
      stall = 1'b1; trap_req = 1'b1; trap_vector = 32'h803;
      tick();
      cti(0, 0, 0, 0, 0); stall = 1'b0; trap_req = 1'b0;
      chk("epc", epc, 32'h20);
      chk("enpc", enpc, 32'h24);
      pair("trap_hold", 32'h20, 32'h24);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("busy%0d", i), 32'(trap_busy), 1);
         chk($sformatf("fv%0d", i), 32'(fetch_valid), 0);
         chk($sformatf("drain_pc%0d", i), pc, 32'h20);
         tick();
      end
      pair("vec", 32'h800, 32'h804);
      chk("vec_busy", 32'(trap_busy), 0);
      chk("vec_fv", 32'(fetch_valid), 1);
      chk("epc_hold", epc, 32'h20);
      cti(1, 1, 1, 1, 32'hFFFF_FFF8);
      tick(); cti(0, 0, 0, 0, 0);
      pair("hi", 32'hFFFF_FFF8, 32'hFFFF_FFFC);
      tick(); pair("wrap", 32'hFFFF_FFFC, 0);
      tick(); pair("wrap2", 0, 4);
      trap_req = 1'b1;
      tick(); trap_req = 1'b0;
      tick(); chk("mid_busy", 32'(trap_busy), 1);
      #2 reset = 1'b1;
      #1 pair("drain_rst", 0, 4);
      chk("drain_rst_busy", 32'(trap_busy), 0);
      chk("drain_rst_fv", 32'(fetch_valid), 1);
      chk("drain_rst_epc", epc, 0);
      reset = 1'b0;
      tick(); pair("post_rst", 4, 8);
      chk("post_rst_busy", 32'(trap_busy), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
